// File: rtl/game_input_ctrl.sv
// game_input_ctrl: button front-end and game-mode FSM for the flappy-bird core.
// Synchronises and debounces flap/start/pause, turns each debounced press
// into one event, arbitrates events against collide and drives the game FSM.
module game_input_ctrl #(
   parameter int DB_CYCLES = 12,
   parameter int CNT_W     = 4,
   parameter int FLAP_GAP  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_flap,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic       collide,
   output logic       flap_pulse,
   output logic       start_pulse,
   output logic       game_run,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam int GAP_W = (FLAP_GAP > 1) ? $clog2(FLAP_GAP) : 1;
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(FLAP_GAP - 1);

   // Button index: 0 flap, 1 start, 2 pause
   logic [2:0]       raw;
   logic [2:0]       s1, s2;
   logic [2:0]       lvl, lvl_d;
   logic [CNT_W-1:0] cnt [3];
   logic [2:0]       ev;
   logic             win_collide, win_pause, win_start, win_flap;
   logic [GAP_W-1:0] gap;
   state_t           st;

   assign raw   = {btn_pause, btn_start, btn_flap};
   assign state = st;

   // Two-flop synchroniser for the asynchronous buttons
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Debounce: level only follows s2 after DB_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl   <= '0;
         lvl_d <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         lvl_d <= lvl;
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == lvl[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               lvl[i] <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Press events and fixed-priority arbitration: collide > pause > start > flap
   always_comb begin
      ev          = lvl & ~lvl_d;
      win_collide = collide;
      win_pause   = ev[2] & ~collide;
      win_start   = ev[1] & ~collide & ~ev[2];
      win_flap    = ev[0] & ~collide & ~ev[2] & ~ev[1];
   end

   // Game-mode FSM with registered pulses, run level and flap gap counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= IDLE;
         flap_pulse  <= 1'b0;
         start_pulse <= 1'b0;
         game_run    <= 1'b0;
         gap         <= '0;
      end else begin
         flap_pulse  <= 1'b0;
         start_pulse <= 1'b0;
         if (gap != '0) gap <= gap - 1'b1;
         case (st)
            IDLE: begin
               // A flap from IDLE starts the game but is not itself a flap
               if (win_start || win_flap) begin
                  st          <= PLAY;
                  start_pulse <= 1'b1;
                  game_run    <= 1'b1;
               end
            end
            PLAY: begin
               if (win_collide) begin
                  st       <= OVER;
                  game_run <= 1'b0;
               end else if (win_pause) begin
                  st       <= PAUSE;
                  game_run <= 1'b0;
               end else if (win_flap && gap == '0) begin
                  flap_pulse <= 1'b1;
                  gap        <= GAP_LOAD;
               end
            end
            PAUSE: begin
               if (win_pause || win_start) begin
                  st       <= PLAY;
                  game_run <= 1'b1;
               end
            end
            OVER: begin
               if (win_start) begin
                  st  <= IDLE;
                  gap <= '0;
               end
            end
            default: begin
               st       <= IDLE;
               game_run <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_input_ctrl.sv
// tb_game_input_ctrl: scoreboard bench for game_input_ctrl.
// Expected output events (cycle, pulses, state, run) are queued when a press
// is driven and popped whenever the DUT shows a pulse or a state change.
module tb_game_input_ctrl;

   localparam int LAT = 15;   // DB_CYCLES + 3 for the main instance

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_flap = 1'b0, btn_start = 1'b0, btn_pause = 1'b0, collide = 1'b0;
   logic       flap_pulse, start_pulse, game_run;
   logic [1:0] state;

   // Second instance with short debounce so flap rises can be close together
   logic       flap2 = 1'b0, start2 = 1'b0, pause2 = 1'b0, collide2 = 1'b0;
   logic       fp2, sp2, run2;
   logic [1:0] st2;

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int fp2_cnt = 0;
   logic [1:0] prev_st = 2'd0;

   typedef struct packed {
      logic [31:0] cyc;
      logic        fp;
      logic        sp;
      logic [1:0]  st;
      logic        run;
   } ev_t;
   ev_t exp_q[$];

   game_input_ctrl dut (
      .clk(clk), .rst_n(rst_n), .btn_flap(btn_flap), .btn_start(btn_start),
      .btn_pause(btn_pause), .collide(collide), .flap_pulse(flap_pulse),
      .start_pulse(start_pulse), .game_run(game_run), .state(state)
   );

   game_input_ctrl #(.DB_CYCLES(2), .CNT_W(2), .FLAP_GAP(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .btn_flap(flap2), .btn_start(start2),
      .btn_pause(pause2), .collide(collide2), .flap_pulse(fp2),
      .start_pulse(sp2), .game_run(run2), .state(st2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, expv, cyc);
      end
   endtask

   task automatic push(input int dly, input logic fp, input logic sp,
                       input logic [1:0] st, input logic run);
      ev_t e;
      e.cyc = 32'(cyc + dly);
      e.fp  = fp;
      e.sp  = sp;
      e.st  = st;
      e.run = run;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_flap  = v;
         1: btn_start = v;
         default: btn_pause = v;
      endcase
   endtask

   // Clean press: hold, release and let the debounced level fall again
   task automatic press(input int b);
      set_btn(b, 1'b1);
      wait_cyc(20);
      set_btn(b, 1'b0);
      wait_cyc(20);
   endtask

   // Monitor: every pulse or state change must match the head of the scoreboard
   always @(negedge clk) begin
      ev_t e;
      if (rst_n) begin
         chk("run_level", game_run, state == 2'd1);
         chk("pulse_excl", flap_pulse & start_pulse, 0);
         if (flap_pulse || start_pulse || state != prev_st) begin
            if (exp_q.size() == 0) begin
               chk("unexp_event", {1'b1, flap_pulse, start_pulse, state, game_run}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("ev_cycle", cyc, e.cyc);
               chk("ev_outputs", {flap_pulse, start_pulse, state, game_run},
                   {e.fp, e.sp, e.st, e.run});
            end
         end
         prev_st = state;
      end else begin
         prev_st = 2'd0;
      end
      if (fp2) fp2_cnt++;
   end

   initial begin
      int base;
      // Reset state, start held from the first edge after release
      btn_start = 1'b1;
      wait_cyc(3);
      chk("rst_state", state, 0);
      chk("rst_outs", {flap_pulse, start_pulse, game_run}, 0);
      rst_n = 1'b1;
      push(LAT, 1'b0, 1'b1, 2'd1, 1'b1);
      wait_cyc(20);
      btn_start = 1'b0;
      wait_cyc(20);

      // Bouncing flap is ignored, the final clean hold flaps once
      for (int i = 0; i < 4; i++) begin
         btn_flap = 1'b1; wait_cyc(5);
         btn_flap = 1'b0; wait_cyc(5);
      end
      btn_flap = 1'b1;
      push(LAT, 1'b1, 1'b0, 2'd1, 1'b1);
      wait_cyc(20);
      btn_flap = 1'b0;
      wait_cyc(20);

      // Flap gap on the short-debounce instance: rises 4 apart, then 9 apart
      start2 = 1'b1; wait_cyc(5); start2 = 1'b0; wait_cyc(10);
      chk("dut2_play", st2, 1);
      base = fp2_cnt;
      flap2 = 1'b1; wait_cyc(2); flap2 = 1'b0; wait_cyc(2);
      flap2 = 1'b1; wait_cyc(2); flap2 = 1'b0; wait_cyc(20);
      chk("gap_drop", fp2_cnt - base, 1);
      base = fp2_cnt;
      flap2 = 1'b1; wait_cyc(4); flap2 = 1'b0; wait_cyc(5);
      flap2 = 1'b1; wait_cyc(4); flap2 = 1'b0; wait_cyc(20);
      chk("gap_accept", fp2_cnt - base, 2);

      // Collide together with pause and flap events: collide wins
      btn_pause = 1'b1;
      btn_flap  = 1'b1;
      push(LAT, 1'b0, 1'b0, 2'd3, 1'b0);
      wait_cyc(LAT - 1);
      collide = 1'b1;
      wait_cyc(1);
      collide = 1'b0;
      wait_cyc(10);
      btn_pause = 1'b0;
      btn_flap  = 1'b0;
      wait_cyc(20);
      push(LAT, 1'b0, 1'b0, 2'd0, 1'b0);
      press(1);
      push(LAT, 1'b0, 1'b1, 2'd1, 1'b1);
      press(1);

      // Pause: flap and collide ignored, start resumes without start_pulse
      push(LAT, 1'b0, 1'b0, 2'd2, 1'b0);
      press(2);
      press(0);
      collide = 1'b1;
      wait_cyc(1);
      collide = 1'b0;
      wait_cyc(5);
      chk("pause_hold", state, 2);
      push(LAT, 1'b0, 1'b0, 2'd1, 1'b1);
      press(1);

      // Reset mid-debounce while in PLAY, button held through release
      chk("pre_rst_play", state, 1);
      btn_start = 1'b1;
      wait_cyc(9);
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", state, 0);
      chk("async_rst_outs", {flap_pulse, start_pulse, game_run}, 0);
      chk("async_rst_dut2", {st2, fp2, sp2, run2}, 0);
      wait_cyc(2);
      rst_n = 1'b1;
      push(LAT, 1'b0, 1'b1, 2'd1, 1'b1);
      wait_cyc(20);
      btn_start = 1'b0;
      wait_cyc(30);

      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/game_input_ctrl.md
Name: game_input_ctrl

Overview:
Front-end controller between the raw board push-buttons and the flappy-bird game core. It synchronises and debounces three buttons (flap, start, pause) and turns each press into a single event. It arbitrates simultaneous events against the core's collision signal and runs the game-mode FSM. The game core sees only clean one-cycle pulses and a run-enable level.

Parameters:
DB_CYCLES, 12, consecutive stable cycles required before a debounced level changes (>=2)
CNT_W, 4, width of debounce counters (2**CNT_W > DB_CYCLES)
FLAP_GAP, 8, minimum cycles from one flap_pulse to the next accepted flap (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
btn_flap  in  1  raw flap button, asynchronous, active-high
btn_start  in  1  raw start button, asynchronous, active-high
btn_pause  in  1  raw pause button, asynchronous, active-high
collide  in  1  synchronous one-cycle pulse from game core: bird hit pipe/ground
flap_pulse  out  1  one-cycle registered pulse: apply flap impulse
start_pulse  out  1  one-cycle registered pulse: game (re)started, core reloads world
game_run  out  1  registered level, 1 only in PLAY
state  out  2  registered FSM state: 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE; flap_pulse, start_pulse, game_run = 0.
  - All sync flops, debounced levels, debounce counters and gap counter = 0.
  - Release is synchronous in effect: first update on first rising edge with rst_n high.
- Sync: each button passes through a 2-flop synchroniser (s1, s2).
- Debounce, per button, with stable level L and counter C:
  - If s2==L: C<=0.
  - Else if C==DB_CYCLES-1: L<=s2, C<=0.
  - Else: C<=C+1.
  - Any bounce back to L before expiry restarts the count; pulses shorter than DB_CYCLES sync cycles are ignored.
- Event: ev_x = L rising (L & ~L_d). Release edges generate nothing. A held button gives exactly one event.
- Latency: take edge 1 as the first edge sampling raw high. L rises at edge DB_CYCLES+2; the output pulse is high after edge DB_CYCLES+3 for exactly one cycle.
- Priority within one cycle: collide > pause > start > flap. Lower-priority events in the same cycle are discarded, not queued.
- FSM transitions (registered; outputs for the new state valid the same edge):
  - IDLE: ev_start or ev_flap -> PLAY, start_pulse=1. A flap from IDLE starts the game without a flap_pulse.
  - PLAY: collide -> OVER. ev_pause -> PAUSE. ev_flap with gap counter==0 -> flap_pulse=1 and gap<=FLAP_GAP-1. ev_flap with gap!=0 is dropped. ev_start is ignored.
  - PAUSE: ev_pause or ev_start -> PLAY, no start_pulse. Flap and collide are ignored.
  - OVER: ev_start -> IDLE. All other events are ignored. A second start press is needed to play.
- Gap counter: decrements to 0 and saturates. It runs in all states and resets to 0 on entry to IDLE.
- game_run = (state==PLAY), registered. Never high in the same cycle as a state other than PLAY.
- flap_pulse and start_pulse are never high simultaneously, and never high two consecutive cycles.
- Reset mid-press: L clears. A button still held after release is treated as a new press and produces an event DB_CYCLES+3 edges later.

Test Plan:
1. Reset, then hold btn_start high from edge 1 -> start_pulse high only after edge 15; state 0->1; game_run 1 from edge 15.
2. In PLAY, btn_flap toggling every 5 cycles for 40 cycles, then held -> no flap_pulse during toggling; exactly one flap_pulse 15 edges after the final rise.
3. In PLAY, two clean flap presses whose debounced rises are 4 cycles apart (FLAP_GAP=8) -> first gives flap_pulse, second dropped. Repeat with 9 cycles apart -> two flap_pulses.
4. In PLAY, collide pulsed in the same cycle as ev_pause and ev_flap -> state=3 next edge, game_run=0, no flap_pulse; then start press -> state=0, next start press -> state=1 with start_pulse.
5. In PLAY, pause press -> state=2, game_run=0; flap press and collide ignored (state stays 2); start press -> state=1, start_pulse stays 0.
6. Assert rst_n low mid-debounce (counter=7) and mid-PLAY -> all outputs 0 immediately (before next edge); button still held after release -> event after full 15-edge latency.
